// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, latches one
// operation, executes it for one cycle, then holds the result until its owner consumes it.
module alu_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [1:0]  req0_op,
    output logic        rsp0_valid,
    output logic [7:0]  rsp0_y,
    input  logic        rsp0_ready,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [1:0]  req1_op,
    output logic        rsp1_valid,
    output logic [7:0]  rsp1_y,
    input  logic        rsp1_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    input  logic [7:0]  alu_y,
    output logic        busy,
    output logic        grant_id,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  y_q, y_d;
    logic [1:0]  op_q, op_d;
    logic        gid_q, gid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        rsp0_vld_q, rsp0_vld_d;
    logic        rsp1_vld_q, rsp1_vld_d;
    logic [15:0] cnt_q, cnt_d;
    logic        win;
    logic        accept;
    logic        rsp_hs;

    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            win = (RR_EN != 0) ? ~last_q : 1'b0;
        end else if (req1_valid) begin
            win = 1'b1;
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !win;
    assign req1_ready = accept && win;
    assign rsp_hs     = (state_q == RESP) && (gid_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        y_d     = y_q;
        gid_d   = gid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = win ? req1_a  : req0_a;
                    b_d     = win ? req1_b  : req0_b;
                    op_d    = win ? req1_op : req0_op;
                    gid_d   = win;
                    last_d  = win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d     = alu_y;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        rsp0_vld_d = (state_d == RESP) && !gid_d;
        rsp1_vld_d = (state_d == RESP) && gid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            op_q       <= 2'd0;
            y_q        <= 8'h00;
            gid_q      <= 1'b0;
            last_q     <= 1'b1;
            busy_q     <= 1'b0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            cnt_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            y_q        <= y_d;
            gid_q      <= gid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp1_vld_q <= rsp1_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp0_valid = rsp0_vld_q;
    assign rsp1_valid = rsp1_vld_q;
    assign rsp0_y     = y_q;
    assign rsp1_y     = y_q;
    assign busy       = busy_q;
    assign grant_id   = gid_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority instance
// share the same stimulus, each with its own external ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id;
    logic [7:0]  rsp0_y, rsp1_y, alu_a, alu_b, alu_y;
    logic [1:0]  alu_op;
    logic [15:0] op_count;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy, fp_grant_id;
    logic [7:0]  fp_rsp0_y, fp_rsp1_y, fp_alu_a, fp_alu_b, fp_alu_y;
    logic [1:0]  fp_alu_op;
    logic [15:0] fp_op_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_y    = alu_model(alu_a, alu_b, alu_op);
    assign fp_alu_y = alu_model(fp_alu_a, fp_alu_b, fp_alu_op);

    alu_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y), .rsp1_ready(rsp1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(fp_rsp0_valid), .rsp0_y(fp_rsp0_y), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(fp_rsp1_valid), .rsp1_y(fp_rsp1_y), .rsp1_ready(rsp1_ready),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op), .alu_y(fp_alu_y),
        .busy(fp_busy), .grant_id(fp_grant_id), .op_count(fp_op_count)
    );

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_op = 2'd0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 2'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic set_req(input bit n, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        if (n) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_y, rsp1_y} !== 18'h0) begin
            errors++; $display("FAIL reset_rsp: got %h want 0", {rsp0_valid, rsp1_valid, rsp0_y, rsp1_y});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 18'h0) begin
            errors++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_op});
        end
        checks++;
        if ({busy, grant_id, op_count} !== 18'h0) begin
            errors++; $display("FAIL reset_status: got %h want 0", {busy, grant_id, op_count});
        end
        checks++;
        if ({fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_rsp0_y, fp_rsp1_y,
             fp_alu_a, fp_alu_b, fp_alu_op, fp_busy, fp_grant_id, fp_op_count} !== 56'h0) begin
            errors++; $display("FAIL reset_fp: got nonzero outputs want all 0");
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        rsp0_ready = 1'b1;
        set_req(1'b0, 8'hF0, 8'h20, 2'd0);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL add_ready: got %b want 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({busy, rsp0_valid, req0_ready, grant_id} !== 4'b1000) begin
            errors++; $display("FAIL add_exec: got %b want 1000", {busy, rsp0_valid, req0_ready, grant_id});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== {8'hF0, 8'h20, 2'd0}) begin
            errors++; $display("FAIL add_alu_in: got %h want %h", {alu_a, alu_b, alu_op}, {8'hF0, 8'h20, 2'd0});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_y} !== {2'b10, 8'h10}) begin
            errors++; $display("FAIL add_rsp: got %h want %h", {rsp0_valid, rsp1_valid, rsp0_y}, {2'b10, 8'h10});
        end
        checks++;
        if (op_count !== 16'd0) begin
            errors++; $display("FAIL add_count_pre: got %0d want 0", op_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, busy, op_count} !== {2'b00, 16'd1}) begin
            errors++; $display("FAIL add_done: got %h want %h", {rsp0_valid, busy, op_count}, {2'b00, 16'd1});
        end
    endtask

    task automatic test_sub();
        @(negedge clk);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(1'b1, 8'h05, 8'h07, 2'd1);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++; $display("FAIL sub_ready: got %b want 10", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checks++;
        if ({busy, grant_id} !== 2'b11) begin
            errors++; $display("FAIL sub_grant: got %b want 11", {busy, grant_id});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp1_y} !== {2'b01, 8'hFE}) begin
            errors++; $display("FAIL sub_rsp: got %h want %h", {rsp0_valid, rsp1_valid, rsp1_y}, {2'b01, 8'hFE});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, op_count} !== {2'b00, 16'd2}) begin
            errors++; $display("FAIL sub_done: got %h want %h", {rsp0_valid, rsp1_valid, op_count}, {2'b00, 16'd2});
        end
        idle_inputs();
    endtask

    task automatic test_withdraw();
        @(negedge clk);
        set_req(1'b0, 8'h11, 8'h22, 2'd0);
        #2 req0_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, grant_id, alu_a, op_count} !== {2'b01, 8'h05, 16'd2}) begin
            errors++; $display("FAIL withdraw: got %h want %h", {busy, grant_id, alu_a, op_count}, {2'b01, 8'h05, 16'd2});
        end
    endtask

    task automatic test_round_robin();
        logic       w;
        logic [7:0] got_y, exp_y;
        apply_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(1'b0, 8'hCC, 8'hAA, 2'd2);
        set_req(1'b1, 8'h0F, 8'hF0, 2'd3);
        for (int k = 0; k < 4; k++) begin
            w = k[0];
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, {req1_ready, req0_ready}, (w ? 2'b10 : 2'b01));
            end
            checks++;
            if ({fp_req1_ready, fp_req0_ready} !== 2'b01) begin
                errors++; $display("FAIL fp_ready[%0d]: got %b want 01", k, {fp_req1_ready, fp_req0_ready});
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            got_y = w ? rsp1_y : rsp0_y;
            exp_y = w ? 8'hFF : 8'h88;
            checks++;
            if ({rsp1_valid, rsp0_valid, got_y} !== {(w ? 2'b10 : 2'b01), exp_y}) begin
                errors++; $display("FAIL rr_rsp[%0d]: got %h want %h", k, {rsp1_valid, rsp0_valid, got_y}, {(w ? 2'b10 : 2'b01), exp_y});
            end
            checks++;
            if ({fp_rsp1_valid, fp_rsp0_valid, fp_rsp0_y} !== {2'b01, 8'h88}) begin
                errors++; $display("FAIL fp_rsp[%0d]: got %h want %h", k, {fp_rsp1_valid, fp_rsp0_valid, fp_rsp0_y}, {2'b01, 8'h88});
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++;
        if ({op_count, fp_op_count} !== {16'd4, 16'd4}) begin
            errors++; $display("FAIL rr_count: got %h want %h", {op_count, fp_op_count}, {16'd4, 16'd4});
        end
    endtask

    task automatic test_stall();
        apply_reset();
        set_req(1'b0, 8'h01, 8'h02, 2'd0);
        set_req(1'b1, 8'h40, 8'h40, 2'd0);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL stall_ready: got %b want 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rsp0_valid, rsp0_y, req1_ready, op_count} !== {1'b1, 8'h03, 1'b0, 16'd0}) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, {rsp0_valid, rsp0_y, req1_ready, op_count}, {1'b1, 8'h03, 1'b0, 16'd0});
            end
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, req1_ready, op_count} !== {2'b01, 16'd1}) begin
            errors++; $display("FAIL stall_release: got %h want %h", {rsp0_valid, req1_ready, op_count}, {2'b01, 16'd1});
        end
        idle_inputs();
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        rsp1_ready = 1'b1;
        set_req(1'b1, 8'h30, 8'h03, 2'd3);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checks++;
        if ({busy, grant_id} !== 2'b11) begin
            errors++; $display("FAIL rexec_exec: got %b want 11", {busy, grant_id});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, grant_id, rsp1_valid, alu_a, alu_b, alu_op, op_count} !== 37'h0) begin
            errors++; $display("FAIL rexec_clear: got %h want 0", {busy, grant_id, rsp1_valid, alu_a, alu_b, alu_op, op_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
                errors++; $display("FAIL rexec_norsp[%0d]: got %b want 000", i, {rsp0_valid, rsp1_valid, busy});
            end
        end
        @(negedge clk);
        rsp0_ready = 1'b1;
        set_req(1'b0, 8'h3C, 8'h0F, 2'd2);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL rexec_accept: got %b want 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, rsp0_y} !== {1'b1, 8'h0C}) begin
            errors++; $display("FAIL rexec_rsp: got %h want %h", {rsp0_valid, rsp0_y}, {1'b1, 8'h0C});
        end
        @(negedge clk);
        #1;
        checks++;
        if (op_count !== 16'd1) begin
            errors++; $display("FAIL rexec_count: got %0d want 1", op_count);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        #1;
        checks++;
        if (op_count !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_preload: got %h want fffe", op_count);
        end
        rsp0_ready = 1'b1;
        set_req(1'b0, 8'h7F, 8'h01, 2'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, rsp0_y} !== {1'b1, 8'h80}) begin
            errors++; $display("FAIL wrap_rsp: got %h want %h", {rsp0_valid, rsp0_y}, {1'b1, 8'h80});
        end
        @(negedge clk);
        #1;
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_ffff: got %h want ffff", op_count);
        end
        set_req(1'b0, 8'hFF, 8'h01, 2'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp0_valid, rsp0_y} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL wrap_rsp2: got %h want %h", {rsp0_valid, rsp0_y}, {1'b1, 8'h00});
        end
        @(negedge clk);
        #1;
        checks++;
        if (op_count !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero: got %h want 0000", op_count);
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_withdraw();
        test_round_robin();
        test_stall();
        test_reset_exec();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  (N=0,1) arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  8 each  (N=0,1) operands.
REQ-007 reqN_op  input  2  (N=0,1) opcode: 0=ADD, 1=SUB, 2=AND, 3=OR.
REQ-008 rspN_valid  output  1  (N=0,1) result for requester N available.
REQ-009 rspN_y  output  8  (N=0,1) result data.
REQ-010 rspN_ready  input  1  (N=0,1) requester N consumes the result.
REQ-011 alu_a, alu_b  output  8 each  operands driven to the shared combinational ALU.
REQ-012 alu_op  output  2  opcode driven to the shared ALU, same encoding as REQ-007.
REQ-013 alu_y  input  8  combinational ALU result.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 grant_id  output  1  index of the requester owning the current or most recent operation.
REQ-016 op_count  output  16  number of completed response handshakes.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-018 IDLE: reqN_ready SHALL be high only for the arbitration winner, combinationally, and only when that requester's valid is high.
REQ-019 Arbitration with one valid: that requester wins. With both valid and RR_EN=1: the requester not granted last wins. With RR_EN=0: requester 0 always wins.
REQ-020 On a valid&&ready transfer, the block SHALL latch a, b, op and the winner index into internal registers, update grant_id, and move to EXEC.
REQ-021 In EXEC and RESP, reqN_ready SHALL be low for both requesters.
REQ-022 alu_a, alu_b and alu_op SHALL be driven from the latched registers in every state.
REQ-023 EXEC lasts exactly one cycle; at its end alu_y SHALL be captured into the result register and the FSM SHALL move to RESP.
REQ-024 RESP: rspN_valid SHALL be high only for N = grant_id. rspN_y SHALL be the captured result and SHALL stay stable while valid.
REQ-025 On rspN_valid&&rspN_ready, the FSM SHALL return to IDLE and op_count SHALL increment by 1.
REQ-026 op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-027 Latency SHALL be: accept in cycle T, EXEC in T+1, rspN_valid high from T+2. The earliest next accept is the cycle after the response handshake.
REQ-028 The non-granted requester's rsp_valid SHALL stay low. Its rsp_ready SHALL be ignored.
REQ-029 A reqN_valid deasserted before acceptance SHALL leave no side effect.
REQ-030 Arithmetic SHALL be modulo 256; ADD/SUB carry and borrow are not reported.
REQ-031 rsp_ready may be held high before rsp_valid rises; the handshake SHALL then complete in the first RESP cycle.

Reset
REQ-032 While rst_n is low, in any state: FSM=IDLE; all reqN_ready and rspN_valid=0; rspN_y=0x00; alu_a, alu_b, alu_op=0; busy=0; grant_id=0; op_count=0.
REQ-033 The round-robin last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-034 A reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-035 Operation SHALL resume from IDLE on the first rising edge after rst_n deasserts.

Verification
REQ-036 Sequence: req0 ADD a=0xF0 b=0x20 accepted at T. Required: rsp0_valid at T+2 with rsp0_y=0x10, and op_count=1 after the handshake.
REQ-037 Sequence: req1 SUB a=0x05 b=0x07. Required: rsp1_y=0xFE; rsp0_valid stays 0; grant_id=1.
REQ-038 Sequence: both valid held after reset, RR_EN=1, ops AND 0xCC&0xAA and OR 0x0F|0xF0. Required: req0 served first (y=0x88), then req1 (y=0xFF), alternating thereafter. With RR_EN=0, req0 is always served.
REQ-039 Sequence: rsp0_ready held low for 5 RESP cycles. Required: rsp0_valid and rsp0_y stay stable; req1_ready stays 0; handshake and op_count increment occur on the cycle rsp0_ready rises.
REQ-040 Sequence: rst_n pulsed low during EXEC. Required: all outputs return to their REQ-032 values immediately; no response is issued; a new request is accepted after release.
REQ-041 Sequence: op_count preloaded near wrap, or 65536 operations run. Required: op_count wraps 0xFFFF to 0x0000 on the next handshake.
